// File: rtl/elevator_request_panel.sv
// Request side of the elevator controller: latches call buttons, schedules
// pending calls with a SCAN sweep, and drives the target floor and door dwell.
module elevator_request_panel #(
  parameter int N_FLOORS  = 5,
  parameter int POS_W     = 5,
  parameter int DWELL_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] btn,
  input  logic [POS_W-1:0]    floor_pos,
  output logic [POS_W-1:0]    floor_req,
  output logic                req_valid,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up,
  output logic                door_open,
  output logic                pos_err
);

  localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DWELL_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    DWELL = 2'd3
  } state_t;

  state_t              state;
  state_t              nxt_state;
  logic [N_FLOORS-1:0] btn_q;
  logic [N_FLOORS-1:0] press;
  logic [N_FLOORS-1:0] ref_hot;
  logic [N_FLOORS-1:0] clr_mask;
  logic [N_FLOORS-1:0] pend_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [POS_W-1:0]    ref_pos;
  logic [POS_W-1:0]    lowest_above;
  logic [POS_W-1:0]    highest_below;
  logic [POS_W-1:0]    nxt_req;
  logic                above;
  logic                below;
  logic                here;
  logic                press_here;
  logic                pos_ok;
  logic                prefer_up;
  logic                nxt_dir;

  assign press  = btn & ~btn_q;
  assign pos_ok = {1'b0, floor_pos} < (POS_W + 1)'(N_FLOORS);
  // While parked, floor_req holds the stop floor, so floor_pos is ignored.
  assign ref_pos = (state == DWELL) ? floor_req : floor_pos;

  always_comb begin
    above         = 1'b0;
    below         = 1'b0;
    here          = 1'b0;
    press_here    = 1'b0;
    lowest_above  = '0;
    highest_below = '0;
    ref_hot       = '0;
    for (int unsigned j = 0; j < N_FLOORS; j++) begin
      if (POS_W'(j) == ref_pos) begin
        ref_hot[j] = 1'b1;
        here       = pending[j];
        press_here = press[j];
      end
      if (pending[j] && (POS_W'(j) > ref_pos) && !above) begin
        above        = 1'b1;
        lowest_above = POS_W'(j);
      end
      if (pending[j] && (POS_W'(j) < ref_pos)) begin
        below         = 1'b1;
        highest_below = POS_W'(j);
      end
    end
  end

  always_comb begin
    prefer_up = (state == DWELL) ? dir_up : (state != DOWN);
    nxt_state = state;
    nxt_dir   = dir_up;
    if ((state != DWELL && (here || press_here)) ||
        (state == DWELL && (press_here || cnt != '0))) begin
      nxt_state = DWELL;
    end else if (above && (prefer_up || !below)) begin
      nxt_state = UP;
      nxt_dir   = 1'b1;
    end else if (below) begin
      nxt_state = DOWN;
      nxt_dir   = 1'b0;
    end else begin
      nxt_state = IDLE;
    end

    case (nxt_state)
      UP:      nxt_req = lowest_above;
      DOWN:    nxt_req = highest_below;
      default: nxt_req = ref_pos;
    endcase

    // The stop floor is served by the dwell itself, so it never becomes pending.
    clr_mask = (nxt_state == DWELL) ? ref_hot : '0;
    pend_nxt = (pending | press) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pending   <= '0;
      floor_req <= '0;
      req_valid <= 1'b0;
      dir_up    <= 1'b1;
      door_open <= 1'b0;
      pos_err   <= 1'b0;
      btn_q     <= '0;
      cnt       <= '0;
    end else begin
      btn_q <= btn;
      if (!pos_ok) begin
        pos_err <= 1'b1;
      end else begin
        state     <= nxt_state;
        dir_up    <= nxt_dir;
        pending   <= pend_nxt;
        floor_req <= nxt_req;
        req_valid <= (nxt_state == UP) || (nxt_state == DOWN);
        door_open <= (nxt_state == DWELL);
        if (nxt_state == DWELL && (state != DWELL || press_here)) begin
          cnt <= CNT_INIT;
        end else if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_elevator_request_panel.sv
// Bench for elevator_request_panel: directed vector table, corner sequences,
// and random traffic compared against a behavioural SCAN model.
module tb_elevator_request_panel;

  localparam int NF    = 5;
  localparam int DWELL = 4;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DWELL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic [4:0] floor_pos;
  logic [4:0] floor_req;
  logic       req_valid;
  logic [4:0] pending;
  logic       dir_up;
  logic       door_open;
  logic       pos_err;

  int errors = 0;
  int checks = 0;

  elevator_request_panel #(.N_FLOORS(5), .POS_W(5), .DWELL_CYC(4)) dut (
    .clk(clk), .rst(rst), .btn(btn), .floor_pos(floor_pos),
    .floor_req(floor_req), .req_valid(req_valid), .pending(pending),
    .dir_up(dir_up), .door_open(door_open), .pos_err(pos_err)
  );

  always #5 clk = ~clk;

  // behavioural model state
  int         m_mode;
  logic [4:0] m_pend;
  int         m_req;
  bit         m_dir;
  bit         m_err;
  logic [4:0] m_prev;
  int         m_left;
  int         m_park;

  task automatic model_step(input logic r, input logic [4:0] b, input int pos);
    logic [4:0] pr;
    int refp, up_t, dn_t;
    bit go_up_first;
    if (!r) begin
      m_mode = M_IDLE; m_pend = '0; m_req = 0; m_dir = 1; m_err = 0;
      m_prev = '0; m_left = 0; m_park = 0;
      return;
    end
    pr = b & ~m_prev;
    m_prev = b;
    if (pos >= NF) begin
      m_err = 1;
      return;
    end
    refp = (m_mode == M_DWELL) ? m_park : pos;
    up_t = -1;
    for (int j = NF - 1; j > refp; j--) if (m_pend[j]) up_t = j;
    dn_t = -1;
    for (int j = 0; j < refp; j++) if (m_pend[j]) dn_t = j;
    if (m_mode != M_DWELL && (m_pend[refp] || pr[refp])) begin
      m_mode = M_DWELL; m_park = refp; m_left = DWELL;
    end else if (m_mode == M_DWELL && pr[refp]) begin
      m_left = DWELL;
    end else if (m_mode == M_DWELL && m_left > 1) begin
      m_left--;
    end else begin
      go_up_first = (m_mode == M_DWELL) ? m_dir : (m_mode != M_DOWN);
      if (up_t >= 0 && (go_up_first || dn_t < 0)) begin
        m_mode = M_UP; m_dir = 1;
      end else if (dn_t >= 0) begin
        m_mode = M_DOWN; m_dir = 0;
      end else begin
        m_mode = M_IDLE;
      end
    end
    m_pend = m_pend | pr;
    if (m_mode == M_DWELL) m_pend[m_park] = 1'b0;
    case (m_mode)
      M_UP:    m_req = up_t;
      M_DOWN:  m_req = dn_t;
      M_DWELL: m_req = m_park;
      default: m_req = refp;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    int act, exp;
    act = {floor_req, req_valid, pending, dir_up, door_open, pos_err};
    exp = {5'(m_req), (m_mode == M_UP || m_mode == M_DOWN), m_pend, m_dir,
           (m_mode == M_DWELL), m_err};
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] b, input logic [4:0] p);
    @(negedge clk);
    rst = r; btn = b; floor_pos = p;
    @(posedge clk);
    model_step(r, b, int'(p));
    #1;
  endtask

  typedef struct {
    logic r; logic [4:0] b; logic [4:0] pos;
    logic [4:0] req; logic valid; logic [4:0] pend; logic dir; logic door; logic err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cur_pos;
    logic [4:0] b;
    rst = 1'b0; btn = '0; floor_pos = '0;

    // rst btn pos | req valid pend dir door err
    tbl.push_back('{1'b0, 5'b00000, 5'd0, 5'd0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 5'b00000, 5'd0, 5'd0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 5'b01000, 5'd0, 5'd0, 1'b0, 5'b01000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 5'b00000, 5'd0, 5'd3, 1'b1, 5'b01000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 5'b00000, 5'd1, 5'd3, 1'b1, 5'b01000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 5'b00000, 5'd2, 5'd3, 1'b1, 5'b01000, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{1'b1, 5'b00000, 5'd3, 5'd3, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 5'b00000, 5'd3, 5'd3, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 5'b00100, 5'd3, 5'd3, 1'b0, 5'b00100, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 5'b00000, 5'd3, 5'd2, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{1'b1, 5'b00000, 5'd2, 5'd2, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 5'b00000, 5'd2, 5'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 5'b00000, 5'd7, 5'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 5'b00000, 5'd0, 5'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 5'b00000, 5'd0, 5'd0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0});

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].b, tbl[k].pos);
      chk($sformatf("tbl%0d floor_req", k), floor_req, tbl[k].req);
      chk($sformatf("tbl%0d req_valid", k), req_valid, tbl[k].valid);
      chk($sformatf("tbl%0d pending", k), pending, tbl[k].pend);
      chk($sformatf("tbl%0d dir_up", k), dir_up, tbl[k].dir);
      chk($sformatf("tbl%0d door_open", k), door_open, tbl[k].door);
      chk($sformatf("tbl%0d pos_err", k), pos_err, tbl[k].err);
    end

    // sweep up to 4 first, then reverse to 1
    step(1'b0, 5'b00000, 5'd2);
    step(1'b1, 5'b10010, 5'd2);
    chk("scan pending", pending, 5'b10010);
    step(1'b1, 5'b00000, 5'd2);
    chk("scan first req", floor_req, 4);
    chk("scan first dir", dir_up, 1);
    step(1'b1, 5'b00000, 5'd3);
    step(1'b1, 5'b00000, 5'd4);
    chk("scan stop door", door_open, 1);
    chk("scan stop pending", pending, 5'b00010);
    repeat (3) step(1'b1, 5'b00000, 5'd4);
    step(1'b1, 5'b00000, 5'd4);
    chk("scan reverse dir", dir_up, 0);
    chk("scan reverse req", floor_req, 1);
    chk("scan reverse valid", req_valid, 1);
    chk_model("scan model");

    // call at current floor, then re-press extends dwell
    step(1'b0, 5'b00000, 5'd2);
    step(1'b1, 5'b00100, 5'd2);
    chk("here door", door_open, 1);
    chk("here pending", pending, 5'b00000);
    step(1'b1, 5'b00000, 5'd2);
    step(1'b1, 5'b00000, 5'd2);
    step(1'b1, 5'b00100, 5'd2);
    chk("repress pending", pending, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'b00000, 5'd2);
      chk($sformatf("repress door hold%0d", k), door_open, 1);
    end
    step(1'b1, 5'b00000, 5'd2);
    chk("repress door drop", door_open, 0);
    chk("repress valid", req_valid, 0);

    // reset while sweeping up drops all calls
    step(1'b0, 5'b00000, 5'd0);
    step(1'b1, 5'b10110, 5'd0);
    step(1'b1, 5'b00000, 5'd0);
    chk("mid pending", pending, 5'b10110);
    chk("mid req", floor_req, 1);
    step(1'b0, 5'b00000, 5'd0);
    chk("rst pending", pending, 5'b00000);
    chk("rst req", floor_req, 0);
    chk("rst valid", req_valid, 0);
    chk("rst dir", dir_up, 1);

    // random traffic against the model
    cur_pos = 0;
    b = '0;
    step(1'b0, 5'b00000, 5'd0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) != 0) b = ($urandom_range(6) == 0) ? 5'(1 << $urandom_range(4)) : 5'b0;
      if (m_mode == M_UP || m_mode == M_DOWN) begin
        if ($urandom_range(2) != 0) cur_pos += (m_req > cur_pos) ? 1 : ((m_req < cur_pos) ? -1 : 0);
      end
      if ($urandom_range(40) == 0) cur_pos = $urandom_range(NF - 1);
      if ($urandom_range(400) == 0)
        step(1'b1, b, 5'($urandom_range(31, NF)));
      else
        step(($urandom_range(300) != 0), b, 5'(cur_pos));
      chk_model($sformatf("rand cyc%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
